factorial_seq: RTL

Parametrised, clocked factorial engine: computes n! of an N_WIDTH-bit unsigned operand with one multiply per clock, using a start/done handshake and a sticky overflow flag. It replaces the single-cycle combinational for-loop factorial wherever area or timing closure matters, and it scales to operand and result widths the loop version cannot reach.

---
 rtl/factorial_seq.sv | 117 +++++++++++
 1 files changed

// File: rtl/factorial_seq.sv
// Sequential factorial engine: one multiply per clock, start/done handshake,
// sticky overflow flag reported alongside the truncated result.
module factorial_seq #(
  parameter int unsigned N_WIDTH = 4,
  parameter int unsigned Z_WIDTH = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_WIDTH-1:0] n,
  output logic               busy,
  output logic               done,
  output logic [Z_WIDTH-1:0] z,
  output logic               overflow
);

  localparam int unsigned IW = N_WIDTH + 1;
  localparam int unsigned PW = Z_WIDTH + N_WIDTH + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [Z_WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]      i_q, i_d;
  logic [N_WIDTH-1:0] limit_q, limit_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [Z_WIDTH-1:0] z_q, z_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [PW-1:0]      product;
  logic               prod_hi;
  logic               finished;

  // Full-width product so bits lost to truncation can be detected.
  assign product  = PW'(acc_q) * PW'(i_q);
  assign prod_hi  = |product[PW-1:Z_WIDTH];
  assign finished = (i_q > {1'b0, limit_q});

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    i_d       = i_q;
    limit_d   = limit_q;
    ovf_acc_d = ovf_acc_q;
    z_d       = z_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          limit_d   = n;
          acc_d     = Z_WIDTH'(1);
          i_d       = IW'(2);
          ovf_acc_d = 1'b0;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        if (finished) begin
          z_d     = acc_q;
          ovf_d   = ovf_acc_q;
          state_d = StDone;
        end else begin
          acc_d     = product[Z_WIDTH-1:0];
          ovf_acc_d = ovf_acc_q | prod_hi;
          i_d       = i_q + IW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status flags are registered copies of the next state.
    busy_d = (state_d == StCalc);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      i_q       <= '0;
      limit_q   <= '0;
      ovf_acc_q <= 1'b0;
      z_q       <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      i_q       <= i_d;
      limit_q   <= limit_d;
      ovf_acc_q <= ovf_acc_d;
      z_q       <= z_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign z        = z_q;
  assign overflow = ovf_q;

endmodule
